// File: rtl/color_token_tx.sv
`default_nettype none
// ============================================================================
// Module   : color_token_tx
// Purpose  : Buffers color-token requests in a small FIFO and drives them onto
//            a 64-bit bus, every token a visible value change (seq field).
//            Define COLOR_TS_EN to replace the payload with a free-running
//            timestamp captured at load time.
// Revision : 1.0 - initial release
// ============================================================================
module color_token_tx #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1,
    parameter int GAP   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [15:0] req_color,
    input  logic [7:0]  req_kind,
    input  logic [31:0] req_payload,
    output logic [63:0] out0,
    output logic        busy,
    output logic [15:0] tx_cnt
);

    localparam int             c_aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             c_cw       = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
    localparam int             c_hold_eff = (HOLD < 1) ? 1 : HOLD;
    localparam logic [3:0]     c_hold_ld  = 4'(c_hold_eff - 1);
    localparam logic [3:0]     c_gap_ld   = 4'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_drive = 2'd1;
    localparam logic [1:0] c_gap   = 2'd2;

`ifdef COLOR_TS_EN
    localparam int c_dw = 24;
`else
    localparam int c_dw = 56;
`endif

    logic [c_dw-1:0] r_mem [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [c_dw-1:0] w_push_data;
    logic [c_dw-1:0] w_head;
    logic [31:0]     w_field;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_hold;
    logic [3:0]  w_hold_nxt;
    logic [3:0]  r_gap;
    logic [3:0]  w_gap_nxt;
    logic [6:0]  r_seq;
    logic [6:0]  w_seq_nxt;
    logic [63:0] r_out0;
    logic [63:0] w_out_nxt;
    logic [15:0] r_tx;
    logic        w_done;

    // Readiness comes from the registered count only; a same-cycle pop never frees a slot.
    assign req_rdy = rst_n && (r_count < c_depth);
    assign w_push  = req_vld && req_rdy;
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rptr];

`ifdef COLOR_TS_EN
    logic [31:0] r_ts;
    logic        w_unused_payload;

    assign w_push_data      = {req_kind, req_color};
    assign w_field          = r_ts;
    assign w_unused_payload = ^req_payload;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end
`else
    assign w_push_data = {req_kind, req_color, req_payload};
    assign w_field     = w_head[31:0];
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_hold  <= '0;
            r_gap   <= '0;
            r_seq   <= '0;
            r_out0  <= '0;
            r_tx    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_gap   <= w_gap_nxt;
            r_seq   <= w_seq_nxt;
            r_out0  <= w_out_nxt;
            r_tx    <= r_tx + 16'(w_done);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_gap_nxt   = r_gap;
        w_out_nxt   = r_out0;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_idle: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_drive;
                    w_hold_nxt  = c_hold_ld;
                end
            end
            c_drive: begin
                if (r_hold == '0) begin
                    w_done = 1'b1;
                    if (GAP > 0) begin
                        w_state_nxt = c_gap;
                        w_gap_nxt   = c_gap_ld;
                    end else if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_hold_nxt = c_hold_ld;
                    end else begin
                        w_state_nxt = c_idle;
                    end
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            c_gap: begin
                if (r_gap == '0) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = c_drive;
                        w_hold_nxt  = c_hold_ld;
                    end else begin
                        w_state_nxt = c_idle;
                    end
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
        // A word loaded as the previous token retires carries the already-incremented seq.
        w_seq_nxt = r_seq + 7'(w_done);
        if (w_pop) begin
            w_out_nxt = {1'b1, w_seq_nxt, w_head[c_dw-1 -: 24], w_field};
        end else if (w_state_nxt != c_drive) begin
            w_out_nxt = '0;
        end
    end

    assign out0   = r_out0;
    assign tx_cnt = r_tx;
    assign busy   = (r_state != c_idle) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_color_token_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_token_tx
// Purpose  : Three color_token_tx configurations on shared stimulus, each
//            compared every cycle against a timeline model of token emission.
// Revision : 1.0 - initial release
// ============================================================================
module tb_color_token_tx;

    localparam int NI = 3;
    localparam int DP = 4;
    localparam int HP [NI] = '{1, 1, 4};
    localparam int GP [NI] = '{1, 0, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld;
    logic [15:0] req_color;
    logic [7:0]  req_kind;
    logic [31:0] req_payload;
    logic [NI-1:0] rdy;
    logic [NI-1:0] busy;
    logic [63:0] out0 [NI];
    logic [15:0] txc  [NI];
    logic [81:0] obs  [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            color_token_tx #(
                .DEPTH(DP),
                .HOLD (HP[gi]),
                .GAP  (GP[gi])
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .req_vld    (req_vld),
                .req_rdy    (rdy[gi]),
                .req_color  (req_color),
                .req_kind   (req_kind),
                .req_payload(req_payload),
                .out0       (out0[gi]),
                .busy       (busy[gi]),
                .tx_cnt     (txc[gi])
            );
            assign obs[gi] = {out0[gi], rdy[gi], busy[gi], txc[gi]};
        end
    endgenerate

    // Model: token k loads at the first edge where it is queued and the previous
    // token has had HOLD+GAP cycles; it shows for HOLD cycles with seq = k mod 128.
    logic [55:0] m_pend [NI][$];
    int          m_t    [NI];
    int          m_last [NI];
    int          m_ntok [NI];
    bit          m_have [NI];
    logic [63:0] m_word [NI];
    logic [81:0] m_exp  [NI];
    logic [31:0] m_ts = '0;

    int checks = 0;
    int errors = 0;

    task automatic step(input logic vld, input logic rn, input logic [15:0] c,
                        input logic [7:0] k, input logic [31:0] p);
        logic        acc;
        logic        act;
        logic [55:0] e;
        req_vld     = vld;
        rst_n       = rn;
        req_color   = c;
        req_kind    = k;
        req_payload = p;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!rn) begin
                m_pend[i].delete();
                m_t[i]    = 0;
                m_ntok[i] = 0;
                m_have[i] = 1'b0;
            end else begin
                acc    = vld && (m_pend[i].size() < DP);
                m_t[i] = m_t[i] + 1;
                if (m_pend[i].size() > 0 && (!m_have[i] || m_t[i] >= m_last[i] + HP[i] + GP[i])) begin
                    e = m_pend[i].pop_front();
`ifdef COLOR_TS_EN
                    m_word[i] = {1'b1, 7'(m_ntok[i]), e[55:32], m_ts};
`else
                    m_word[i] = {1'b1, 7'(m_ntok[i]), e};
`endif
                    m_ntok[i] = m_ntok[i] + 1;
                    m_have[i] = 1'b1;
                    m_last[i] = m_t[i];
                end
                if (acc) m_pend[i].push_back({k, c, p});
            end
        end
        m_ts = rn ? m_ts + 32'd1 : 32'd0;
        for (int i = 0; i < NI; i++) begin
            act = m_have[i] && (m_t[i] < m_last[i] + HP[i]);
            m_exp[i] = {act ? m_word[i] : 64'h0,
                        rn && (m_pend[i].size() < DP),
                        (m_pend[i].size() > 0) || (m_have[i] && m_t[i] < m_last[i] + HP[i] + GP[i]),
                        16'(m_ntok[i] - (act ? 1 : 0))};
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b0, 16'($urandom), 8'($urandom), $urandom);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs[i] !== m_exp[i]) begin
                    errors++;
                    $display("FAIL reset_model dut%0d got %h exp %h", i, obs[i], m_exp[i]);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (out0[i] !== 64'h0 || rdy[i] !== 1'b0 || busy[i] !== 1'b0 || txc[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d got out0=%h rdy=%b busy=%b tx=%0d exp 0/0/0/0",
                         i, out0[i], rdy[i], busy[i], txc[i]);
            end
        end
        step(1'b0, 1'b1, 16'h0, 8'h0, 32'h0);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (rdy[i] !== 1'b1 || busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL release_rdy dut%0d got rdy=%b busy=%b exp 1/0", i, rdy[i], busy[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [63:0] exp_word;
`ifdef COLOR_TS_EN
        exp_word = 64'h8003_00A5_0000_0001;
`else
        exp_word = 64'h8003_00A5_1234_5678;
`endif
        step(1'b0, 1'b0, 16'h0, 8'h0, 32'h0);
        for (int n = 0; n < 10; n++) begin
            step(n == 0, 1'b1, 16'h00A5, 8'h03, 32'h1234_5678);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs[i] !== m_exp[i]) begin
                    errors++;
                    $display("FAIL single_model dut%0d cyc %0d got %h exp %h", i, n, obs[i], m_exp[i]);
                end
            end
            if (n == 1) begin
                checks++;
                if (out0[0] !== exp_word) begin
                    errors++;
                    $display("FAIL single_word got %h exp %h", out0[0], exp_word);
                end
            end
            if (n == 2) begin
                checks++;
                if (out0[0] !== 64'h0 || txc[0] !== 16'd1) begin
                    errors++;
                    $display("FAIL single_after got out0=%h tx=%0d exp 0/1", out0[0], txc[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] hist [8];
        step(1'b0, 1'b0, 16'h0, 8'h0, 32'h0);
        for (int n = 0; n < 8; n++) begin
            step(n < 3, 1'b1, 16'h1234, 8'h55, 32'hCAFE_F00D);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs[i] !== m_exp[i]) begin
                    errors++;
                    $display("FAIL b2b_model dut%0d cyc %0d got %h exp %h", i, n, obs[i], m_exp[i]);
                end
            end
            hist[n] = out0[1];
        end
        for (int j = 1; j < 4; j++) begin
            checks++;
            if (hist[j][63:56] !== {1'b1, 7'(j - 1)} || hist[j][55:32] !== 24'h55_1234) begin
                errors++;
                $display("FAIL b2b_seq cyc %0d got %h exp seq %0d", j, hist[j], j - 1);
            end
        end
        checks++;
        if (hist[4] !== 64'h0 || txc[1] !== 16'd3) begin
            errors++;
            $display("FAIL b2b_end got out0=%h tx=%0d exp 0/3", hist[4], txc[1]);
        end
    endtask

    task automatic test_full();
        int acc;
        acc = 0;
        step(1'b0, 1'b0, 16'h0, 8'h0, 32'h0);
        step(1'b0, 1'b1, 16'h0, 8'h0, 32'h0);
        for (int n = 0; n < 56; n++) begin
            if (n < 6 && rdy[2] === 1'b1) acc++;
            step(n < 16, 1'b1, 16'($urandom), 8'($urandom), $urandom);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs[i] !== m_exp[i]) begin
                    errors++;
                    $display("FAIL full_model dut%0d cyc %0d got %h exp %h", i, n, obs[i], m_exp[i]);
                end
            end
        end
        checks++;
        if (acc != 5) begin
            errors++;
            $display("FAIL full_accepts got %0d exp 5", acc);
        end
    endtask

    task automatic test_seq_wrap();
        logic [6:0] seqs [$];
        step(1'b0, 1'b0, 16'h0, 8'h0, 32'h0);
        for (int n = 0; n < 140; n++) begin
            step(n < 130, 1'b1, 16'($urandom), 8'($urandom), $urandom);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs[i] !== m_exp[i]) begin
                    errors++;
                    $display("FAIL wrap_model dut%0d cyc %0d got %h exp %h", i, n, obs[i], m_exp[i]);
                end
            end
            if (out0[1][63] === 1'b1) seqs.push_back(out0[1][62:56]);
        end
        checks++;
        if (seqs.size() != 130 || txc[1] !== 16'd130) begin
            errors++;
            $display("FAIL wrap_count got tokens=%0d tx=%0d exp 130/130", seqs.size(), txc[1]);
        end
        if (seqs.size() >= 130) begin
            checks++;
            if (seqs[127] !== 7'd127 || seqs[128] !== 7'd0 || seqs[129] !== 7'd1) begin
                errors++;
                $display("FAIL wrap_seq got %0d,%0d,%0d exp 127,0,1", seqs[127], seqs[128], seqs[129]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 16'h0, 8'h0, 32'h0);
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b1, 16'($urandom), 8'($urandom), $urandom);
        end
        step(1'b0, 1'b0, 16'h0, 8'h0, 32'h0);
        checks++;
        if (out0[2] !== 64'h0 || busy[2] !== 1'b0 || txc[2] !== 16'h0 || rdy[2] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got out0=%h busy=%b tx=%0d rdy=%b exp 0/0/0/0",
                     out0[2], busy[2], txc[2], rdy[2]);
        end
        for (int n = 0; n < 12; n++) begin
            step(n == 0, 1'b1, 16'hBEEF, 8'h7E, $urandom);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs[i] !== m_exp[i]) begin
                    errors++;
                    $display("FAIL mid_model dut%0d cyc %0d got %h exp %h", i, n, obs[i], m_exp[i]);
                end
            end
            if (n == 1) begin
                checks++;
                if (out0[2][63:32] !== 32'h807E_BEEF) begin
                    errors++;
                    $display("FAIL mid_seq got %h exp 807ebeef", out0[2][63:32]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 4) != 0, ($urandom % 64) != 0, 16'($urandom), 8'($urandom), $urandom);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs[i] !== m_exp[i]) begin
                    errors++;
                    $display("FAIL random_model dut%0d cyc %0d got %h exp %h", i, n, obs[i], m_exp[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        req_vld     = 1'b0;
        req_color   = '0;
        req_kind    = '0;
        req_payload = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_seq_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
